// File: rtl/imu_spi_seq.sv
// imu_spi_seq: SPI command sequencer that configures an IMU and reads pitch/yaw rates on each data-ready interrupt.
// Optional build macro IMU_OVRN_CNT_EN adds ovrn_cnt, a saturating count of interrupts lost to an already-pending read.
module imu_spi_seq #(
  parameter int POR_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] ptch_rt,
  output logic [15:0] yaw_rt,
  output logic        vld,
  output logic        cfg_done
`ifdef IMU_OVRN_CNT_EN
  ,
  output logic [7:0]  ovrn_cnt
`endif
);
  typedef enum logic [2:0] {POR, CFG, CFG_WAIT, IDLE, RD, RD_WAIT, UPD} state_t;
  state_t state_q, state_d;
  logic [POR_BITS-1:0] por_cnt_q, por_cnt_d;
  logic [1:0] idx_q, idx_d;
  logic [15:0] cmd_q, cmd_d, ptch_q, ptch_d, yaw_q, yaw_d;
  logic [2:0][7:0] rx_q, rx_d;
  logic cfg_done_q, cfg_done_d;
  logic int_s1_q, int_s2_q, int_s3_q;
  logic int_pend_q, int_pend_d;
  logic done_q;
  logic int_rise, xfer_cmplt, start_rd;
  logic unused_hi;
  assign unused_hi = ^rd_data[15:8];
  assign int_rise = int_s2_q & ~int_s3_q;
  assign xfer_cmplt = done & ~done_q;
  // A rise arriving in the same cycle a burst starts must not be lost, so set beats clear
  assign int_pend_d = int_rise | (int_pend_q & ~start_rd);
  function automatic logic [15:0] cfg_tab(input logic [1:0] i);
    return i == 2'd0 ? 16'h0D02 : i == 2'd1 ? 16'h1160 : 16'h1440;
  endfunction
  function automatic logic [15:0] rd_tab(input logic [1:0] i);
    return i == 2'd0 ? 16'hA200 : i == 2'd1 ? 16'hA300 : i == 2'd2 ? 16'hA600 : 16'hA700;
  endfunction
  // State and datapath registers, plus the INT synchroniser and done edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= POR;
      por_cnt_q  <= '0;
      idx_q      <= 2'd0;
      cmd_q      <= 16'h0000;
      ptch_q     <= 16'h0000;
      yaw_q      <= 16'h0000;
      rx_q       <= '0;
      cfg_done_q <= 1'b0;
      int_s1_q   <= 1'b0;
      int_s2_q   <= 1'b0;
      int_s3_q   <= 1'b0;
      int_pend_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      por_cnt_q  <= por_cnt_d;
      idx_q      <= idx_d;
      cmd_q      <= cmd_d;
      ptch_q     <= ptch_d;
      yaw_q      <= yaw_d;
      rx_q       <= rx_d;
      cfg_done_q <= cfg_done_d;
      int_s1_q   <= INT;
      int_s2_q   <= int_s1_q;
      int_s3_q   <= int_s2_q;
      int_pend_q <= int_pend_d;
      done_q     <= done;
    end
  end
  // Next state; cmd is loaded only when entering CFG/RD so it is stable for the whole transaction
  always_comb begin
    state_d    = state_q;
    por_cnt_d  = por_cnt_q;
    idx_d      = idx_q;
    ptch_d     = ptch_q;
    yaw_d      = yaw_q;
    rx_d       = rx_q;
    cfg_done_d = cfg_done_q;
    start_rd   = 1'b0;
    case (state_q)
      POR: begin
        por_cnt_d = por_cnt_q + POR_BITS'(1);
        if (&por_cnt_q) begin
          state_d = CFG;
          idx_d   = 2'd0;
        end
      end
      CFG: state_d = CFG_WAIT;
      CFG_WAIT: if (xfer_cmplt) begin
        if (idx_q == 2'd2) begin
          state_d    = IDLE;
          cfg_done_d = 1'b1;
        end else begin
          state_d = CFG;
          idx_d   = idx_q + 2'd1;
        end
      end
      IDLE: if (int_pend_q) begin
        state_d  = RD;
        idx_d    = 2'd0;
        start_rd = 1'b1;
      end
      RD: state_d = RD_WAIT;
      RD_WAIT: if (xfer_cmplt) begin
        if (idx_q == 2'd3) begin
          state_d = UPD;
          ptch_d  = {rx_q[1], rx_q[0]};
          yaw_d   = {rd_data[7:0], rx_q[2]};
        end else begin
          rx_d[idx_q] = rd_data[7:0];
          state_d     = RD;
          idx_d       = idx_q + 2'd1;
        end
      end
      UPD: state_d = IDLE;
      default: state_d = POR;
    endcase
    cmd_d = state_d == CFG ? cfg_tab(idx_d) : state_d == RD ? rd_tab(idx_d) : cmd_q;
  end
  // Moore outputs: wrt pulses in the single-cycle issue states, vld in the update state
  always_comb begin
    wrt      = state_q == CFG || state_q == RD;
    vld      = state_q == UPD;
    cmd      = cmd_q;
    ptch_rt  = ptch_q;
    yaw_rt   = yaw_q;
    cfg_done = cfg_done_q;
  end
`ifdef IMU_OVRN_CNT_EN
  logic [7:0] ovrn_q, ovrn_d;
  assign ovrn_d = (int_rise & int_pend_q & ~&ovrn_q) ? ovrn_q + 8'd1 : ovrn_q;
  assign ovrn_cnt = ovrn_q;
  // Saturating count of interrupts that arrive while a read is already pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovrn_q <= 8'd0;
    else ovrn_q <= ovrn_d;
  end
`endif
endmodule

// File: tb/tb_imu_spi_seq.sv
// tb_imu_spi_seq: directed bench for imu_spi_seq with a done/rd_data responder model.
module tb_imu_spi_seq;
  localparam int LAT = 40;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic INT = 1'b0;
  logic done = 1'b1;
  logic [15:0] rd_data = 16'h0000;
  logic wrt, vld, cfg_done;
  logic [15:0] cmd, ptch_rt, yaw_rt;
`ifdef IMU_OVRN_CNT_EN
  logic [7:0] ovrn_cnt;
`endif
  int checks = 0;
  int failures = 0;
  int vld_cnt = 0;
  logic [15:0] wlog[$];
  logic [7:0] p_lo = 8'h00, p_hi = 8'h00, y_lo = 8'h00, y_hi = 8'h00;
  logic [15:0] cur_cmd = 16'h0000;
  int t = 0;
  logic [15:0] cfgc [3] = '{16'h0D02, 16'h1160, 16'h1440};
  logic [15:0] rdc [4] = '{16'hA200, 16'hA300, 16'hA600, 16'hA700};
  typedef struct {
    logic [7:0]  pl, ph, yl, yh;
    logic [15:0] ep, ey;
  } vec_t;
  vec_t vecs [3];

  imu_spi_seq #(.POR_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .ptch_rt(ptch_rt), .yaw_rt(yaw_rt), .vld(vld),
    .cfg_done(cfg_done)
`ifdef IMU_OVRN_CNT_EN
    , .ovrn_cnt(ovrn_cnt)
`endif
  );

  always #5 clk = ~clk;

  // SPI master model: done stays stale-high through the wrt cycle, drops, and rises LAT cycles later
  always @(negedge clk) begin
    if (!rst_n) begin
      t = 0;
      done = 1'b1;
    end else if (wrt) begin
      t = LAT;
      cur_cmd = cmd;
    end else if (t > 0) begin
      t = t - 1;
      done = (t == 0);
      if (t == 0)
        case (cur_cmd)
          16'hA200: rd_data = {8'hEE, p_lo};
          16'hA300: rd_data = {8'hEE, p_hi};
          16'hA600: rd_data = {8'hEE, y_lo};
          16'hA700: rd_data = {8'hEE, y_hi};
          default:  rd_data = 16'hFFFF;
        endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (wrt) wlog.push_back(cmd);
      if (vld) vld_cnt = vld_cnt + 1;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_wlog(input int n, input int lim, input string name);
    int k = 0;
    while (wlog.size() < n && k < lim) begin
      tick();
      k++;
    end
    if (wlog.size() < n) chk({name, "_timeout"}, wlog.size(), n);
  endtask

  task automatic wait_vld(input int n, input int lim, input string name);
    int k = 0;
    while (vld_cnt < n && k < lim) begin
      tick();
      k++;
    end
    if (vld_cnt < n) chk({name, "_timeout"}, vld_cnt, n);
  endtask

  task automatic pulse_int();
    INT = 1'b1;
    repeat (3) tick();
    INT = 1'b0;
    repeat (3) tick();
  endtask

  task automatic por_and_cfg(input bit int_in_por, input string tag);
    int n = 0;
    while (!wrt && n < 100) begin
      tick();
      n++;
      if (int_in_por && n == 3) INT = 1'b1;
      if (int_in_por && n == 6) INT = 1'b0;
    end
    chk({tag, "_first_wrt_cycle"}, n, 16);
    n = 0;
    while (!cfg_done && n < 500) begin
      tick();
      n++;
    end
    chk({tag, "_cfg_done"}, cfg_done, 1'b1);
    chk({tag, "_cfg_wrt_count"}, wlog.size(), 3);
    for (int i = 0; i < 3; i++)
      chk({tag, "_cfg_cmd", string'(8'(48 + i))}, wlog.size() > i ? wlog[i] : 16'hXXXX, cfgc[i]);
  endtask

  initial begin
    vecs[0] = '{8'h34, 8'h12, 8'hCD, 8'hAB, 16'h1234, 16'hABCD};
    vecs[1] = '{8'h80, 8'hFF, 8'h01, 8'h00, 16'hFF80, 16'h0001};
    vecs[2] = '{8'hFF, 8'h7F, 8'h00, 8'h80, 16'h7FFF, 16'h8000};
    repeat (3) tick();
    chk("rst_outputs", {wrt, vld, cfg_done, cmd}, 19'h0);
    chk("rst_rates", {ptch_rt, yaw_rt}, 32'h0);
    rst_n = 1'b1;
    // INT pulsed during POR must be held pending until configuration is finished
    p_lo = 8'h34; p_hi = 8'h12; y_lo = 8'hCD; y_hi = 8'hAB;
    por_and_cfg(1'b1, "por");
    wait_vld(1, 1000, "por_burst");
    chk("por_burst_ptch", ptch_rt, 16'h1234);
    chk("por_burst_yaw", yaw_rt, 16'hABCD);
    for (int i = 0; i < 4; i++)
      chk("por_burst_cmd", wlog.size() > 3 + i ? wlog[3 + i] : 16'hXXXX, rdc[i]);
    repeat (20) tick();
    for (int v = 0; v < 3; v++) begin
      wlog.delete();
      vld_cnt = 0;
      p_lo = vecs[v].pl; p_hi = vecs[v].ph; y_lo = vecs[v].yl; y_hi = vecs[v].yh;
      pulse_int();
      wait_vld(1, 1000, "vec");
      chk("vec_vld_ptch", ptch_rt, vecs[v].ep);
      chk("vec_vld_yaw", yaw_rt, vecs[v].ey);
      repeat (60) tick();
      chk("vec_vld_count", vld_cnt, 1);
      chk("vec_wrt_count", wlog.size(), 4);
      for (int i = 0; i < 4; i++)
        chk("vec_cmd", wlog.size() > i ? wlog[i] : 16'hXXXX, rdc[i]);
      chk("vec_hold", {ptch_rt, yaw_rt}, {vecs[v].ep, vecs[v].ey});
    end
    // Three INT edges during one burst collapse into one extra burst
    wlog.delete();
    vld_cnt = 0;
    p_lo = 8'h11; p_hi = 8'h22; y_lo = 8'h33; y_hi = 8'h44;
    pulse_int();
    wait_wlog(2, 500, "multi_start");
    repeat (3) pulse_int();
    wait_vld(2, 2000, "multi");
    repeat (200) tick();
    chk("multi_vld_count", vld_cnt, 2);
    chk("multi_wrt_count", wlog.size(), 8);
    chk("multi_rates", {ptch_rt, yaw_rt}, 32'h2211_4433);
`ifdef IMU_OVRN_CNT_EN
    chk("ovrn_cnt", ovrn_cnt, 8'd2);
`endif
    // Reset in the middle of the yaw-low read
    wlog.delete();
    vld_cnt = 0;
    pulse_int();
    wait_wlog(3, 500, "mid_rst_start");
    repeat (5) tick();
    chk("mid_rst_pre_cmd", cmd, 16'hA600);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", {wrt, vld, cfg_done, cmd}, 19'h0);
    chk("mid_rst_rates", {ptch_rt, yaw_rt}, 32'h0);
`ifdef IMU_OVRN_CNT_EN
    chk("mid_rst_ovrn", ovrn_cnt, 8'd0);
`endif
    repeat (2) tick();
    wlog.delete();
    vld_cnt = 0;
    rst_n = 1'b1;
    por_and_cfg(1'b0, "rerun");
    repeat (100) tick();
    chk("rerun_no_burst", vld_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
